multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 imem_ack  in  1  instruction word valid on instr this cycle.
REQ-004 instr  in  32  fetched instruction word.
REQ-005 dmem_ack  in  1  data access complete this cycle.
REQ-006 br_taken  in  1  branch comparison result from ALU, valid in EXEC.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 ir_we  out  1  latch instr into instruction register.
REQ-009 imm_field  out  25  IR[31:7], driven to immediate generator.
REQ-010 imm_sel  out  3  immediate format select.
REQ-011 alu_a_sel  out  1  0 = rs1, 1 = PC.
REQ-012 alu_b_sel  out  1  0 = rs2, 1 = immediate.
REQ-013 alu_op  out  2  00 add, 01 branch compare, 10 decode funct3/funct7.
REQ-014 pc_we  out  1  PC write enable.
REQ-015 pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared.
REQ-016 reg_we  out  1  register file write enable.
REQ-017 wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate.
REQ-018 dmem_req  out  1  data memory request.
REQ-019 dmem_we  out  1  data memory write, meaningful only with dmem_req.
REQ-020 trap  out  1  illegal opcode seen; sticky until rst.
REQ-021 instr_done  out  1  one-cycle pulse on instruction retirement.

Function
REQ-022 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-023 FETCH: imem_req=1; hold until imem_ack; on ack, ir_we=1 and go to DECODE.
REQ-024 DECODE: all outputs combinational from registered IR; illegal opcode -> TRAP, else EXEC.
REQ-025 Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR.
REQ-026 imm_sel map: I-ALU funct3 001/101 -> 101; I-ALU funct3 011 -> 001; other I-ALU, LOAD, JALR -> 000; STORE -> 010; BRANCH -> 011; LUI, AUIPC -> 100; JAL -> 110; R -> 000 (don't-care).
REQ-027 imm_sel and imm_field are driven from IR in DECODE, EXEC, MEM and WB, and are stable across those states.
REQ-028 EXEC, R: alu_a_sel=0, alu_b_sel=0, alu_op=10 -> WB.
REQ-029 EXEC, I-ALU: alu_b_sel=1, alu_op=10 -> WB.
REQ-030 EXEC, LOAD/STORE: alu_b_sel=1, alu_op=00 -> MEM.
REQ-031 EXEC, BRANCH: alu_op=01; pc_we=1, pc_src = br_taken ? 01 : 00; instr_done=1 -> FETCH.
REQ-032 EXEC, LUI/AUIPC/JAL/JALR -> WB. AUIPC: alu_a_sel=1, alu_b_sel=1, alu_op=00. JALR: alu_b_sel=1, alu_op=00.
REQ-033 MEM: dmem_req=1, dmem_we=1 for STORE, else 0; hold until dmem_ack.
REQ-034 MEM, on dmem_ack: STORE -> pc_we=1, pc_src=00, instr_done=1 -> FETCH; LOAD -> WB.
REQ-035 WB: single cycle, reg_we=1, instr_done=1 -> FETCH.
REQ-036 WB wb_sel: R, I-ALU, AUIPC -> 00; LOAD -> 01; JAL, JALR -> 10; LUI -> 11.
REQ-037 WB pc_we=1; pc_src: JAL -> 01, JALR -> 10, otherwise 00.
REQ-038 Minimum latency with same-cycle acks: BRANCH 3 cycles; R, I-ALU, LUI, AUIPC, JAL, JALR, STORE 4 cycles; LOAD 5 cycles.
REQ-039 TRAP: absorbing state; trap=1; every other output 0; leaves only on rst.
REQ-040 Outside the states named above, pc_we, reg_we, dmem_req, ir_we, imem_req and instr_done are 0.
REQ-041 imem_ack outside FETCH and dmem_ack outside MEM are ignored.
REQ-042 Never assert reg_we and dmem_we in the same cycle, and never assert pc_we twice for one instruction.

Reset
REQ-043 While rst=1, the next state is FETCH and IR is cleared to 0x00000013 (NOP); trap is cleared.
REQ-044 While rst=1, all outputs are 0, including imem_req.
REQ-045 rst=1 mid-instruction, including while waiting in FETCH or MEM, aborts the instruction with no pc_we or reg_we.
REQ-046 The first imem_req is asserted in the cycle after rst deasserts.

Verification
REQ-047 ADD x3,x1,x2 (0x002081B3), ack same cycle -> states FETCH, DECODE, EXEC, WB; reg_we in cycle 4; wb_sel=00; pc_src=00.
REQ-048 LW, dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0; WB has wb_sel=01; total 8 cycles.
REQ-049 BEQ with br_taken=1, then br_taken=0 -> imm_sel=011; pc_src=01, then 00; instr_done in cycle 3 each time.
REQ-050 SLLI, SLTIU, JAL, SW, LUI -> imm_sel 101, 001, 110, 010, 100 respectively; JAL WB has wb_sel=10, pc_src=01.
REQ-051 Opcode 0x7F -> trap=1 from the cycle after DECODE; no pc_we or reg_we; rst clears it and returns to FETCH.
REQ-052 rst pulsed during MEM of SW with dmem_ack=1 in the same cycle -> no pc_we; state FETCH next cycle; all outputs 0 during rst.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a trap state
// for unrecognised opcodes. All datapath controls are decoded from the registered IR.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic [24:0] imm_field,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        trap,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_IALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_ILLEGAL
  } iclass_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  iclass_t     iclass;
  logic [2:0]  funct3;
  logic [2:0]  imm_sel_dec;

  assign funct3 = ir_q[14:12];

  always_comb begin
    iclass = C_ILLEGAL;
    case (ir_q[6:0])
      7'b0110011: iclass = C_R;
      7'b0010011: iclass = C_IALU;
      7'b0000011: iclass = C_LOAD;
      7'b0100011: iclass = C_STORE;
      7'b1100011: iclass = C_BRANCH;
      7'b0110111: iclass = C_LUI;
      7'b0010111: iclass = C_AUIPC;
      7'b1101111: iclass = C_JAL;
      7'b1100111: iclass = C_JALR;
      default:    iclass = C_ILLEGAL;
    endcase
  end

  // Shift-immediates use the shamt format; SLTIU needs the unsigned-compare variant.
  always_comb begin
    imm_sel_dec = 3'b000;
    case (iclass)
      C_IALU: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_sel_dec = 3'b101;
        end else if (funct3 == 3'b011) begin
          imm_sel_dec = 3'b001;
        end else begin
          imm_sel_dec = 3'b000;
        end
      end
      C_STORE:        imm_sel_dec = 3'b010;
      C_BRANCH:       imm_sel_dec = 3'b011;
      C_LUI, C_AUIPC: imm_sel_dec = 3'b100;
      C_JAL:          imm_sel_dec = 3'b110;
      default:        imm_sel_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    imm_field  = '0;
    imm_sel    = 3'b000;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    alu_op     = 2'b00;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    wb_sel     = 2'b00;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    trap       = 1'b0;
    instr_done = 1'b0;

    // Reset silences every output so an interrupted instruction has no side effects.
    if (!rst) begin
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        imm_field = ir_q[31:7];
        imm_sel   = imm_sel_dec;
      end

      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            ir_d    = instr;
            state_d = S_DECODE;
          end
        end

        S_DECODE: begin
          state_d = (iclass == C_ILLEGAL) ? S_TRAP : S_EXEC;
        end

        S_EXEC: begin
          case (iclass)
            C_R: begin
              alu_op  = 2'b10;
              state_d = S_WB;
            end
            C_IALU: begin
              alu_b_sel = 1'b1;
              alu_op    = 2'b10;
              state_d   = S_WB;
            end
            C_LOAD, C_STORE: begin
              alu_b_sel = 1'b1;
              state_d   = S_MEM;
            end
            C_BRANCH: begin
              alu_op     = 2'b01;
              pc_we      = 1'b1;
              pc_src     = br_taken ? 2'b01 : 2'b00;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            C_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
              state_d   = S_WB;
            end
            C_JALR: begin
              alu_b_sel = 1'b1;
              state_d   = S_WB;
            end
            C_LUI, C_JAL: begin
              state_d = S_WB;
            end
            default: state_d = S_TRAP;
          endcase
        end

        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (iclass == C_STORE);
          if (dmem_ack) begin
            if (iclass == C_STORE) begin
              pc_we      = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end

        S_WB: begin
          reg_we     = 1'b1;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
          case (iclass)
            C_LOAD:        wb_sel = 2'b01;
            C_JAL, C_JALR: wb_sel = 2'b10;
            C_LUI:         wb_sel = 2'b11;
            default:       wb_sel = 2'b00;
          endcase
          case (iclass)
            C_JAL:   pc_src = 2'b01;
            C_JALR:  pc_src = 2'b10;
            default: pc_src = 2'b00;
          endcase
        end

        S_TRAP: begin
          trap = 1'b1;
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: each row is one instruction with its expected
// control behaviour; expectations queue at fetch and are checked at retirement.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] instr;
  logic        dmem_ack;
  logic        br_taken;
  logic        imem_req;
  logic        ir_we;
  logic [24:0] imm_field;
  logic [2:0]  imm_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  alu_op;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        trap;
  logic        instr_done;

  logic [43:0] all_out;
  assign all_out = {imem_req, ir_we, imm_field, imm_sel, alu_a_sel, alu_b_sel, alu_op,
                    pc_we, pc_src, reg_we, wb_sel, dmem_req, dmem_we, trap, instr_done};

  localparam logic [43:0] ONLY_IMEM_REQ = 44'h800_0000_0000;
  localparam logic [43:0] ONLY_TRAP     = 44'h000_0000_0002;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .dmem_ack   (dmem_ack),
    .br_taken   (br_taken),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .imm_field  (imm_field),
    .imm_sel    (imm_sel),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .alu_op     (alu_op),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .trap       (trap),
    .instr_done (instr_done)
  );

  typedef struct {
    logic [31:0] instr;
    logic        br_taken;
    int          imem_delay;
    int          dmem_delay;
    int          exp_cycles;
    logic [2:0]  exp_imm_sel;
    logic        chk_alu;
    logic [3:0]  exp_alu;      // {alu_a_sel, alu_b_sel, alu_op} in EXEC
    logic [1:0]  exp_pc_src;
    int          exp_reg_we;
    logic [1:0]  exp_wb_sel;
    int          exp_dmem_cycles;
    logic        exp_dmem_we;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic br, input int id, input int dd,
                              input int cyc, input logic [2:0] isel, input logic ca,
                              input logic [3:0] alu, input logic [1:0] pcs, input int rw,
                              input logic [1:0] wb, input int dc, input logic dwe);
    vec_t v;
    v.instr = ins; v.br_taken = br; v.imem_delay = id; v.dmem_delay = dd;
    v.exp_cycles = cyc; v.exp_imm_sel = isel; v.chk_alu = ca; v.exp_alu = alu;
    v.exp_pc_src = pcs; v.exp_reg_we = rw; v.exp_wb_sel = wb;
    v.exp_dmem_cycles = dc; v.exp_dmem_we = dwe;
    return v;
  endfunction

  // Runs one instruction starting in FETCH; acks outside FETCH/MEM are held high as noise.
  task automatic run_instr(input vec_t v, input int idx);
    int          cyc, mem_cyc, dec_cyc, pcw, regw, irw, imreq;
    bit          done, conflict, unstable;
    logic [1:0]  pcs, wbs;
    logic [2:0]  isel;
    logic [24:0] ifield;
    logic [3:0]  alu;
    logic        dwe;
    logic [31:0] ins;
    vec_t        e;
    cyc = 0; mem_cyc = 0; pcw = 0; regw = 0; irw = 0; imreq = 0;
    done = 0; conflict = 0; unstable = 0;
    pcs = 2'b11; wbs = 2'b00; isel = 3'b111; ifield = '0; alu = 4'hF; dwe = 1'b0;
    dec_cyc = v.imem_delay + 2;
    exp_q.push_back(v);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      rst      = 1'b0;
      imem_ack = (cyc >= v.imem_delay + 1);
      instr    = (cyc == v.imem_delay + 1) ? v.instr : $urandom();
      br_taken = v.br_taken;
      dmem_ack = 1'b1;
      #1;
      if (dmem_req) begin
        mem_cyc++;
        dmem_ack = (mem_cyc > v.dmem_delay);
      end
      #1;
      if (imem_req) imreq++;
      if (ir_we) irw++;
      if (pc_we) begin pcw++; pcs = pc_src; end
      if (reg_we) begin regw++; wbs = wb_sel; end
      if (dmem_req && dmem_we) dwe = 1'b1;
      if (reg_we && dmem_we) conflict = 1;
      if (trap) conflict = 1;
      if (cyc == dec_cyc) begin isel = imm_sel; ifield = imm_field; end
      if (cyc > dec_cyc && (imm_sel !== isel || imm_field !== ifield)) unstable = 1;
      if (cyc == dec_cyc + 1) alu = {alu_a_sel, alu_b_sel, alu_op};
      if (instr_done) done = 1;
    end
    e   = exp_q.pop_front();
    ins = e.instr;
    $display("txn %0d instr=%08h cycles=%0d pc_we=%0d reg_we=%0d dmem_cycles=%0d",
             idx, ins, cyc, pcw, regw, mem_cyc);
    check("retired", 64'(done), 64'd1);
    check("cycles", 64'(cyc), 64'(e.exp_cycles));
    check("imem_req_cycles", 64'(imreq), 64'(e.imem_delay + 1));
    check("ir_we_count", 64'(irw), 64'd1);
    check("imm_sel", 64'(isel), 64'(e.exp_imm_sel));
    check("imm_field", 64'(ifield), 64'(ins[31:7]));
    check("imm_stable", 64'(unstable), 64'd0);
    if (e.chk_alu) check("alu_ctrl", 64'(alu), 64'(e.exp_alu));
    check("pc_we_count", 64'(pcw), 64'd1);
    check("pc_src", 64'(pcs), 64'(e.exp_pc_src));
    check("reg_we_count", 64'(regw), 64'(e.exp_reg_we));
    if (e.exp_reg_we != 0) check("wb_sel", 64'(wbs), 64'(e.exp_wb_sel));
    check("dmem_cycles", 64'(mem_cyc), 64'(e.exp_dmem_cycles));
    check("dmem_we", 64'(dwe), 64'(e.exp_dmem_we));
    check("no_conflict", 64'(conflict), 64'd0);
  endtask

  initial begin
    //            instr         br id dd cyc isel   ca alu      pcs    rw wb     dc we
    vecs.push_back(mk(32'h002081B3, 0, 0, 0, 4, 3'b000, 1, 4'b0010, 2'b00, 1, 2'b00, 0, 0)); // ADD
    vecs.push_back(mk(32'h0080A283, 0, 0, 3, 8, 3'b000, 1, 4'b0100, 2'b00, 1, 2'b01, 4, 0)); // LW slow
    vecs.push_back(mk(32'h00208463, 1, 0, 0, 3, 3'b011, 1, 4'b0001, 2'b01, 0, 2'b00, 0, 0)); // BEQ taken
    vecs.push_back(mk(32'h00208463, 0, 0, 0, 3, 3'b011, 1, 4'b0001, 2'b00, 0, 2'b00, 0, 0)); // BEQ not
    vecs.push_back(mk(32'h00309093, 0, 0, 0, 4, 3'b101, 1, 4'b0110, 2'b00, 1, 2'b00, 0, 0)); // SLLI
    vecs.push_back(mk(32'h0050B113, 0, 0, 0, 4, 3'b001, 1, 4'b0110, 2'b00, 1, 2'b00, 0, 0)); // SLTIU
    vecs.push_back(mk(32'h010000EF, 0, 0, 0, 4, 3'b110, 0, 4'b0000, 2'b01, 1, 2'b10, 0, 0)); // JAL
    vecs.push_back(mk(32'h0020A223, 0, 0, 0, 4, 3'b010, 1, 4'b0100, 2'b00, 0, 2'b00, 1, 1)); // SW
    vecs.push_back(mk(32'h123452B7, 0, 0, 0, 4, 3'b100, 0, 4'b0000, 2'b00, 1, 2'b11, 0, 0)); // LUI
    vecs.push_back(mk(32'h00001197, 0, 0, 0, 4, 3'b100, 1, 4'b1100, 2'b00, 1, 2'b00, 0, 0)); // AUIPC
    vecs.push_back(mk(32'h000100E7, 0, 0, 0, 4, 3'b000, 1, 4'b0100, 2'b10, 1, 2'b10, 0, 0)); // JALR
    vecs.push_back(mk(32'h4030D093, 0, 0, 0, 4, 3'b101, 1, 4'b0110, 2'b00, 1, 2'b00, 0, 0)); // SRAI
    vecs.push_back(mk(32'h002081B3, 0, 2, 0, 6, 3'b000, 1, 4'b0010, 2'b00, 1, 2'b00, 0, 0)); // ADD slow fetch
    vecs.push_back(mk(32'h0020A223, 0, 0, 2, 6, 3'b010, 1, 4'b0100, 2'b00, 0, 2'b00, 3, 1)); // SW slow
    vecs.push_back(mk(32'h0080A283, 0, 0, 0, 5, 3'b000, 1, 4'b0100, 2'b00, 1, 2'b01, 1, 0)); // LW fast
    vecs.push_back(mk(32'h00100093, 0, 0, 0, 4, 3'b000, 1, 4'b0110, 2'b00, 1, 2'b00, 0, 0)); // ADDI

    // Reset with every input active: all outputs must stay low.
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; br_taken = 1'b1; instr = 32'h0020A223;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 64'(all_out), 64'd0);
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1 check("first_fetch", 64'(all_out), 64'(ONLY_IMEM_REQ));

    foreach (vecs[i]) run_instr(vecs[i], i);

    // Illegal opcode: trap from the cycle after DECODE, absorbing until reset.
    @(negedge clk);
    imem_ack = 1'b1; instr = 32'h0000007F; dmem_ack = 1'b1;
    #1 check("illegal_fetch_ir_we", 64'(ir_we), 64'd1);
    @(negedge clk);
    instr = 32'h002081B3;
    #1 check("illegal_decode_no_trap", 64'(trap), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check("trap_state", 64'(all_out), 64'(ONLY_TRAP));
    end
    @(negedge clk);
    rst = 1'b1;
    #1 check("trap_rst_outputs", 64'(all_out), 64'd0);
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1 check("trap_cleared_fetch", 64'(all_out), 64'(ONLY_IMEM_REQ));

    // Reset during MEM of a store, coinciding with dmem_ack: the store must not retire.
    @(negedge clk);
    imem_ack = 1'b1; instr = 32'h0020A223; dmem_ack = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("sw_mem_reached", 64'({dmem_req, dmem_we}), 64'd3);
    rst = 1'b1; dmem_ack = 1'b1;
    #1 check("mem_rst_outputs", 64'(all_out), 64'd0);
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b0;
    #1 check("mem_rst_fetch", 64'(all_out), 64'(ONLY_IMEM_REQ));
    run_instr(vecs[0], 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
